// File: rtl/wram_bsram_arbiter_if.sv
// Bundle of the CPU/RV request handshakes and the BSRAM macro bus around the WRAM arbiter.
// The slave modport is the arbiter's view; master is the surrounding requesters plus BSRAM.
interface wram_bsram_arbiter_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
);
  logic                  i_cpu_req;
  logic                  i_cpu_we;
  logic [15:0]           i_cpu_addr;
  logic [DATA_WIDTH-1:0] i_cpu_wdata;
  logic                  o_cpu_ack;
  logic [DATA_WIDTH-1:0] o_cpu_rdata;

  logic                  i_rv_req;
  logic                  i_rv_we;
  logic [22:0]           i_rv_addr;
  logic [DATA_WIDTH-1:0] i_rv_wdata;
  logic                  o_rv_ack;
  logic [DATA_WIDTH-1:0] o_rv_rdata;

  logic                  i_wram_load_ongoing;

  logic                  o_mem_en;
  logic                  o_mem_we;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic [DATA_WIDTH-1:0] i_mem_rdata;

  logic                  o_busy;

  modport slave (
    input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    output o_cpu_ack, o_cpu_rdata,
    input  i_rv_req, i_rv_we, i_rv_addr, i_rv_wdata,
    output o_rv_ack, o_rv_rdata,
    input  i_wram_load_ongoing,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata,
    output o_busy
  );

  modport master (
    output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    input  o_cpu_ack, o_cpu_rdata,
    output i_rv_req, i_rv_we, i_rv_addr, i_rv_wdata,
    input  o_rv_ack, o_rv_rdata,
    output i_wram_load_ongoing,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_rdata,
    input  o_busy
  );
endinterface

// File: rtl/wram_bsram_arbiter.sv
// Serialises NES CPU and IOSys RISC-V accesses onto the single-ported 8 KB WRAM BSRAM.
// Each access is IDLE -> GRANT -> RESP; ack pulses in RESP with read data passed straight through.
module wram_bsram_arbiter #(
  parameter int ADDR_WIDTH      = 13,
  parameter int DATA_WIDTH      = 8,
  parameter int RV_STARVE_LIMIT = 4
) (
  input logic                 i_clk,
  input logic                 i_resetn,
  wram_bsram_arbiter_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam int             CNT_W      = $clog2(RV_STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(RV_STARVE_LIMIT);

  logic [1:0]            state;
  logic [CNT_W-1:0]      starve_cnt;
  logic                  sel_rv;
  logic                  acc_hit;
  logic                  acc_is_wr;
  logic                  acc_wr_en;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic [DATA_WIDTH-1:0] rv_rdata_q;

  logic [15:0]           cpu_off;
  logic [22:0]           rv_off;
  logic                  cpu_hit;
  logic                  rv_hit;
  logic                  any_req;
  logic                  rv_wins;
  logic                  mem_en;
  logic                  mem_we;
  logic                  in_resp;
  logic [DATA_WIDTH-1:0] resp_data;

  // Offsets wrap for addresses below the window, so one unsigned compare covers both bounds.
  always_comb begin
    cpu_off = bus.i_cpu_addr - 16'h6000;
    rv_off  = bus.i_rv_addr - 23'h706000;
    cpu_hit = cpu_off < 16'h2000;
    rv_hit  = rv_off < 23'h002000;
    any_req = bus.i_cpu_req || bus.i_rv_req;
    rv_wins = bus.i_rv_req && (bus.i_wram_load_ongoing || (starve_cnt == STARVE_MAX) || !bus.i_cpu_req);
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state       <= ST_IDLE;
      sel_rv      <= 1'b0;
      acc_hit     <= 1'b0;
      acc_is_wr   <= 1'b0;
      acc_wr_en   <= 1'b0;
      acc_idx     <= '0;
      acc_wdata   <= '0;
      cpu_rdata_q <= '0;
      rv_rdata_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state  <= ST_GRANT;
            sel_rv <= rv_wins;
            if (rv_wins) begin
              acc_hit   <= rv_hit;
              acc_idx   <= rv_off[ADDR_WIDTH-1:0];
              acc_is_wr <= bus.i_rv_we;
              acc_wr_en <= bus.i_rv_we;
              acc_wdata <= bus.i_rv_wdata;
            end else begin
              acc_hit   <= cpu_hit;
              acc_idx   <= cpu_off[ADDR_WIDTH-1:0];
              acc_is_wr <= bus.i_cpu_we;
              // CPU writes during a WRAM restore are acknowledged but discarded.
              acc_wr_en <= bus.i_cpu_we && !bus.i_wram_load_ongoing;
              acc_wdata <= bus.i_cpu_wdata;
            end
          end
        end
        ST_GRANT: state <= ST_RESP;
        ST_RESP: begin
          state <= ST_IDLE;
          if (!acc_is_wr) begin
            if (sel_rv) rv_rdata_q <= resp_data;
            else        cpu_rdata_q <= resp_data;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      starve_cnt <= '0;
    end else if (!bus.i_rv_req) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (rv_wins)                       starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign in_resp   = (state == ST_RESP);
  assign resp_data = acc_hit ? bus.i_mem_rdata : '0;
  assign mem_en    = (state == ST_GRANT) && acc_hit;
  assign mem_we    = mem_en && acc_wr_en;

  assign bus.o_mem_en    = mem_en;
  assign bus.o_mem_we    = mem_we;
  assign bus.o_mem_addr  = mem_en ? acc_idx : '0;
  assign bus.o_mem_wdata = mem_we ? acc_wdata : '0;
  assign bus.o_busy      = (state != ST_IDLE);

  assign bus.o_cpu_ack   = in_resp && !sel_rv;
  assign bus.o_rv_ack    = in_resp && sel_rv;
  assign bus.o_cpu_rdata = (in_resp && !sel_rv && !acc_is_wr) ? resp_data : cpu_rdata_q;
  assign bus.o_rv_rdata  = (in_resp && sel_rv && !acc_is_wr) ? resp_data : rv_rdata_q;
endmodule

// File: tb/tb_wram_bsram_arbiter.sv
// Bench for wram_bsram_arbiter: BSRAM behavioural memory, transaction-rule reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_wram_bsram_arbiter;
  localparam int LIMIT = 4;

  logic i_clk = 1'b0;
  logic i_resetn;

  wram_bsram_arbiter_if #(.ADDR_WIDTH(13), .DATA_WIDTH(8)) bus ();

  wram_bsram_arbiter #(
    .ADDR_WIDTH(13),
    .DATA_WIDTH(8),
    .RV_STARVE_LIMIT(LIMIT)
  ) dut (
    .i_clk(i_clk),
    .i_resetn(i_resetn),
    .bus(bus)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic logic [7:0] pattern(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // BSRAM: one-cycle read latency, read-first on write; control sampled mid-cycle.
  logic [7:0] bsram [0:8191];
  initial begin
    logic        cap_en, cap_we;
    logic [12:0] cap_addr;
    logic [7:0]  cap_wd;
    for (int i = 0; i < 8192; i++) bsram[i] = pattern(i);
    bus.i_mem_rdata = 8'h00;
    forever begin
      @(negedge i_clk);
      cap_en   = bus.o_mem_en;
      cap_we   = bus.o_mem_we;
      cap_addr = bus.o_mem_addr;
      cap_wd   = bus.o_mem_wdata;
      @(posedge i_clk);
      if (cap_en) begin
        bus.i_mem_rdata = bsram[cap_addr];
        if (cap_we) bsram[cap_addr] = cap_wd;
      end
    end
  end

  // Reference model: access phase (0 idle, 1 grant, 2 resp) plus its own copy of WRAM contents.
  logic [7:0] ref_mem [0:8191];
  int         m_phase, m_starve, m_idx;
  bit         m_rv, m_hit, m_we, m_wr_ok;
  logic [7:0] m_wd, m_held_cpu, m_held_rv;
  bit         e_busy, e_en, e_we, e_cpu_ack, e_rv_ack;
  logic [12:0] e_addr;
  logic [7:0] e_wd, e_cpu_rd, e_rv_rd;

  function automatic logic [7:0] model_read();
    return m_hit ? ref_mem[m_idx] : 8'h00;
  endfunction

  initial begin
    int a;
    bit cpu_p, rv_p;
    for (int i = 0; i < 8192; i++) ref_mem[i] = pattern(i);
    m_phase = 0; m_starve = 0; m_idx = 0;
    m_rv = 0; m_hit = 0; m_we = 0; m_wr_ok = 0;
    m_wd = 0; m_held_cpu = 0; m_held_rv = 0;
    forever begin
      @(posedge i_clk or negedge i_resetn);
      if (!i_resetn) begin
        m_phase = 0; m_starve = 0; m_held_cpu = 0; m_held_rv = 0;
        m_rv = 0; m_hit = 0; m_we = 0; m_wr_ok = 0;
      end else begin
        cpu_p = bus.i_cpu_req;
        rv_p  = bus.i_rv_req;
        if (m_phase == 0) begin
          if (cpu_p || rv_p) begin
            m_rv = rv_p && (bus.i_wram_load_ongoing || m_starve == LIMIT || !cpu_p);
            if (m_rv) begin
              a = int'(bus.i_rv_addr);
              m_hit = (a >= 'h706000) && (a < 'h708000);
              m_idx = a - 'h706000;
              m_we = bus.i_rv_we; m_wr_ok = m_we; m_wd = bus.i_rv_wdata;
              m_starve = 0;
            end else begin
              a = int'(bus.i_cpu_addr);
              m_hit = (a >= 'h6000) && (a < 'h8000);
              m_idx = a - 'h6000;
              m_we = bus.i_cpu_we; m_wr_ok = m_we && !bus.i_wram_load_ongoing; m_wd = bus.i_cpu_wdata;
              if (rv_p) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
            end
            m_phase = 1;
          end
        end else if (m_phase == 1) begin
          if (m_hit && m_wr_ok) ref_mem[m_idx] = m_wd;
          m_phase = 2;
        end else begin
          if (!m_we) begin
            if (m_rv) m_held_rv = model_read();
            else      m_held_cpu = model_read();
          end
          m_phase = 0;
        end
        if (!rv_p) m_starve = 0;
      end
      e_busy    = (m_phase != 0);
      e_en      = (m_phase == 1) && m_hit;
      e_we      = e_en && m_wr_ok;
      e_addr    = 13'(m_idx);
      e_wd      = m_wd;
      e_cpu_ack = (m_phase == 2) && !m_rv;
      e_rv_ack  = (m_phase == 2) && m_rv;
      e_cpu_rd  = (e_cpu_ack && !m_we) ? model_read() : m_held_cpu;
      e_rv_rd   = (e_rv_ack && !m_we) ? model_read() : m_held_rv;
    end
  end

  int         en_count = 0, wr_count = 0;
  logic [12:0] last_wr_addr = '0;
  logic [7:0] last_wr_data = '0;

  initial begin
    forever begin
      @(negedge i_clk);
      if (i_resetn) begin
        check_output("busy", bus.o_busy, e_busy);
        check_output("mem_en", bus.o_mem_en, e_en);
        check_output("mem_we", bus.o_mem_we, e_we);
        if (e_en) check_output("mem_addr", bus.o_mem_addr, e_addr);
        if (e_we) check_output("mem_wdata", bus.o_mem_wdata, e_wd);
        check_output("cpu_ack", bus.o_cpu_ack, e_cpu_ack);
        check_output("rv_ack", bus.o_rv_ack, e_rv_ack);
        check_output("cpu_rdata", bus.o_cpu_rdata, e_cpu_rd);
        check_output("rv_rdata", bus.o_rv_rdata, e_rv_rd);
        if (bus.o_mem_en) en_count++;
        if (bus.o_mem_en && bus.o_mem_we) begin
          wr_count++;
          last_wr_addr = bus.o_mem_addr;
          last_wr_data = bus.o_mem_wdata;
        end
      end
    end
  end

  // Call just after a rising edge; returns just after the edge that ends the ack cycle.
  task automatic apply_stimulus(input bit is_rv, input bit we, input logic [22:0] addr,
                                input logic [7:0] wdata, output logic [7:0] rdata,
                                output int ack_cyc, output int lat);
    int n;
    bit got;
    n = 0; got = 0; rdata = 8'h00; ack_cyc = -1;
    if (is_rv) begin
      bus.i_rv_req = 1'b1; bus.i_rv_we = we; bus.i_rv_addr = addr; bus.i_rv_wdata = wdata;
    end else begin
      bus.i_cpu_req = 1'b1; bus.i_cpu_we = we; bus.i_cpu_addr = addr[15:0]; bus.i_cpu_wdata = wdata;
    end
    while (!got && n < 60) begin
      @(negedge i_clk);
      n++;
      if (is_rv ? bus.o_rv_ack : bus.o_cpu_ack) begin
        got = 1;
        rdata = is_rv ? bus.o_rv_rdata : bus.o_cpu_rdata;
        ack_cyc = cyc;
      end
    end
    lat = n - 1;
    if (!got) check_output(is_rv ? "rv_ack_timeout" : "cpu_ack_timeout", 32'(got), 32'd1);
    @(posedge i_clk);
    #1;
    if (is_rv) bus.i_rv_req = 1'b0;
    else       bus.i_cpu_req = 1'b0;
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] rd_c, rd_r;
    int ack_c, ack_r, lat_c, lat_r, wc0, ec0, rv_ack1, rv_ack2;
    int cpu_acks [10];

    i_resetn = 1'b0;
    bus.i_cpu_req = 0; bus.i_cpu_we = 0; bus.i_cpu_addr = 0; bus.i_cpu_wdata = 0;
    bus.i_rv_req = 0;  bus.i_rv_we = 0;  bus.i_rv_addr = 0;  bus.i_rv_wdata = 0;
    bus.i_wram_load_ongoing = 0;
    #1;
    check_output("rst_busy", bus.o_busy, 0);
    check_output("rst_cpu_ack", bus.o_cpu_ack, 0);
    check_output("rst_rv_ack", bus.o_rv_ack, 0);
    check_output("rst_mem_en", bus.o_mem_en, 0);
    check_output("rst_mem_we", bus.o_mem_we, 0);
    check_output("rst_mem_addr", bus.o_mem_addr, 0);
    check_output("rst_mem_wdata", bus.o_mem_wdata, 0);
    check_output("rst_cpu_rdata", bus.o_cpu_rdata, 0);
    check_output("rst_rv_rdata", bus.o_rv_rdata, 0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    #2 i_resetn = 1'b1;
    @(posedge i_clk);
    #1;

    $display("[TB] CPU write then read $6005");
    apply_stimulus(0, 1, 23'h6005, 8'hA5, rd_c, ack_c, lat_c);
    check_output("t1_wr_lat", lat_c, 2);
    check_output("t1_wr_addr", last_wr_addr, 13'h0005);
    check_output("t1_wr_data", last_wr_data, 8'hA5);
    apply_stimulus(0, 0, 23'h6005, 8'h00, rd_c, ack_c, lat_c);
    check_output("t1_rd_lat", lat_c, 2);
    check_output("t1_rd_data", rd_c, 8'hA5);

    $display("[TB] simultaneous CPU and RV reads");
    fork
      apply_stimulus(0, 0, 23'h6010, 8'h00, rd_c, ack_c, lat_c);
      apply_stimulus(1, 0, 23'h706020, 8'h00, rd_r, ack_r, lat_r);
    join
    check_output("t2_cpu_lat", lat_c, 2);
    check_output("t2_rv_after_cpu", ack_r - ack_c, 3);
    check_output("t2_cpu_data", rd_c, 8'h73);
    check_output("t2_rv_data", rd_r, 8'hE3);

    $display("[TB] CPU streaming reads with RV pending");
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          int a_k, l_k;
          logic [7:0] d_k;
          apply_stimulus(0, 0, 23'h6100 + 23'(k), 8'h00, d_k, a_k, l_k);
          cpu_acks[k] = a_k;
        end
      end
      begin
        apply_stimulus(1, 0, 23'h706040, 8'h00, rd_r, rv_ack1, lat_r);
        apply_stimulus(1, 0, 23'h706041, 8'h00, rd_r, rv_ack2, lat_r);
      end
    join
    check_output("t3_cpu_back_to_back", cpu_acks[1] - cpu_acks[0], 3);
    check_output("t3_rv_after_4_cpu", rv_ack1 - cpu_acks[3], 3);
    check_output("t3_cpu_resumes", cpu_acks[4] - rv_ack1, 3);
    check_output("t3_rv_again_after_4", rv_ack2 - cpu_acks[7], 3);

    $display("[TB] WRAM load: RV priority and CPU write protection");
    wc0 = wr_count;
    bus.i_wram_load_ongoing = 1'b1;
    fork
      apply_stimulus(0, 1, 23'h7FFF, 8'hFF, rd_c, ack_c, lat_c);
      apply_stimulus(1, 1, 23'h707FFF, 8'h3C, rd_r, ack_r, lat_r);
    join
    bus.i_wram_load_ongoing = 1'b0;
    check_output("t4_cpu_after_rv", ack_c - ack_r, 3);
    check_output("t4_write_count", wr_count - wc0, 1);
    check_output("t4_wr_addr", last_wr_addr, 13'h1FFF);
    check_output("t4_wr_data", last_wr_data, 8'h3C);
    apply_stimulus(0, 0, 23'h7FFF, 8'h00, rd_c, ack_c, lat_c);
    check_output("t4_cpu_readback", rd_c, 8'h3C);

    $display("[TB] out-of-window requests");
    ec0 = en_count;
    fork
      apply_stimulus(0, 0, 23'h8000, 8'h00, rd_c, ack_c, lat_c);
      apply_stimulus(1, 0, 23'h705FFF, 8'h00, rd_r, ack_r, lat_r);
    join
    check_output("t5_cpu_data", rd_c, 8'h00);
    check_output("t5_rv_data", rd_r, 8'h00);
    check_output("t5_no_mem_en", en_count - ec0, 0);

    $display("[TB] reset during RESP");
    bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = 16'h6005;
    @(negedge i_clk);
    @(negedge i_clk);
    @(posedge i_clk);
    #2;
    check_output("t6_ack_in_resp", bus.o_cpu_ack, 1);
    i_resetn = 1'b0;
    #1;
    bus.i_cpu_req = 1'b0;
    check_output("t6_ack_cleared", bus.o_cpu_ack, 0);
    check_output("t6_busy_cleared", bus.o_busy, 0);
    check_output("t6_mem_en_cleared", bus.o_mem_en, 0);
    check_output("t6_cpu_rdata_cleared", bus.o_cpu_rdata, 0);
    check_output("t6_rv_rdata_cleared", bus.o_rv_rdata, 0);
    @(posedge i_clk);
    @(negedge i_clk);
    #2 i_resetn = 1'b1;
    @(negedge i_clk);
    check_output("t6_idle_after_release", bus.o_busy, 0);
    check_output("t6_no_ack_after_release", bus.o_cpu_ack, 0);
    @(posedge i_clk);
    #1;
    apply_stimulus(0, 0, 23'h6005, 8'h00, rd_c, ack_c, lat_c);
    check_output("t6_post_reset_lat", lat_c, 2);
    check_output("t6_post_reset_data", rd_c, 8'hA5);

    repeat (3) @(posedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/wram_bsram_arbiter.md
Name: wram_bsram_arbiter

Overview:
Sequences all accesses to the 8 KB WRAM block RAM, which is single-ported. Two requesters share it: the NES CPU (window $6000-$7FFF) and the IOSys RISC-V core (window $706000-$707FFF). The block uses a level request/pulse acknowledge handshake per requester and a small FSM. CPU has priority, RV wins while WRAM load is ongoing, and an anti-starvation counter stops the CPU from locking RV out. Sits between the CPU/RV address decode and the BSRAM macro, replacing direct BSRAM access.

Parameters:
ADDR_WIDTH, 13, BSRAM index width (8192 bytes)
DATA_WIDTH, 8, BSRAM data width
RV_STARVE_LIMIT, 4, consecutive CPU grants allowed while RV is pending before RV is forced

Ports:
i_clk  in  1  system clock
i_resetn  in  1  reset, asynchronous, active-low
i_cpu_req  in  1  CPU request, level, held until o_cpu_ack
i_cpu_we  in  1  1=write, 0=read
i_cpu_addr  in  16  NES address
i_cpu_wdata  in  8  write data
o_cpu_ack  out  1  one-cycle completion pulse
o_cpu_rdata  out  8  read data, valid with o_cpu_ack, held until next CPU ack
i_rv_req  in  1  RV request, level, held until o_rv_ack
i_rv_we  in  1  1=write (any wstrb set), 0=read
i_rv_addr  in  23  RV byte address
i_rv_wdata  in  8  write data (low byte of selected halfword)
o_rv_ack  out  1  one-cycle completion pulse
o_rv_rdata  out  8  read data, valid with o_rv_ack, held until next RV ack
i_wram_load_ongoing  in  1  RV is restoring WRAM; RV gets priority and CPU writes are dropped
o_mem_en  out  1  BSRAM enable
o_mem_we  out  1  BSRAM write enable
o_mem_addr  out  ADDR_WIDTH  BSRAM index
o_mem_wdata  out  8  BSRAM write data
i_mem_rdata  in  8  BSRAM read data, one-cycle latency after o_mem_en
o_busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE, starve counter 0, all outputs 0 (including both rdata registers).
- Decode:
  - CPU hit when $6000 <= addr <= $7FFF; index = addr - $6000.
  - RV hit when $706000 <= addr <= $707FFF; index = addr - $706000.
  - Upper bound is exclusive of $8000 / $708000.
- Out-of-window request: granted normally, but o_mem_en stays 0 and no write occurs. Ack is returned with rdata = 8'h00.
- FSM:
  - IDLE: if any req is pending, select a winner and go to GRANT.
  - GRANT (1 cycle): drive o_mem_en/o_mem_we/o_mem_addr/o_mem_wdata from the winner's registered request; go to RESP.
  - RESP (1 cycle): capture i_mem_rdata into the winner's rdata register (reads only; writes leave rdata unchanged); pulse winner ack; go to IDLE.
- Latency: req sampled high in IDLE -> ack is asserted exactly 2 cycles later, 3 cycles per access. Peak throughput is one access per 3 cycles.
- Handshake:
  - The requester holds req, addr, we and wdata stable until it sees ack.
  - It drops req in the cycle after ack.
  - IDLE following RESP therefore never re-serves the same transaction.
- Arbitration in IDLE:
  - load_ongoing=1: RV wins whenever pending.
  - Else if the starve counter equals RV_STARVE_LIMIT and RV is pending: RV wins.
  - Else CPU wins whenever pending.
  - Only one requester is granted per cycle, so simultaneous writes cannot occur.
- Starve counter:
  - +1 on each CPU grant while RV is pending, saturating at RV_STARVE_LIMIT.
  - Cleared on an RV grant or whenever RV is not pending.
- Write protection: a CPU write granted while load_ongoing=1 is acked but o_mem_we=0 and the BSRAM is unchanged. CPU reads are unaffected. load_ongoing is sampled at grant.
- Winner request fields are latched at entry to GRANT; a change of load_ongoing mid-access does not alter the in-flight access.
- Reset mid-access: the access is aborted with no ack. A write already driven in GRANT stands.
- o_busy=1 in GRANT and RESP.

Test Plan:
1. CPU write $6005=8'hA5, then CPU read $6005 -> mem write index 13'h0005. Read ack 2 cycles after req with o_cpu_rdata=8'hA5.
2. CPU and RV both request reads in the same cycle, load_ongoing=0 -> CPU acked first; RV acked 3 cycles later.
3. CPU issues back-to-back reads continuously while RV is pending -> RV granted after exactly 4 CPU grants; counter returns to 0.
4. load_ongoing=1, RV write $707FFF=8'h3C, plus CPU write $7FFF=8'hFF at the same time -> RV first, writing index 13'h1FFF. CPU acked with no write. Subsequent CPU read of $7FFF returns 8'h3C.
5. CPU read $8000 and RV read $705FFF -> both acked with rdata 8'h00; o_mem_en never asserted.
6. Assert i_resetn=0 during RESP -> ack stays 0, all outputs 0 asynchronously, FSM in IDLE after release.
